// File: rtl/multi_input_counter_pkg.sv
// Shared types and default parameters for the multi-channel gated edge counter.
package multi_input_counter_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_SYNC_STAGES = 2;

    // Encoding 2'b11 is treated like EDGE_RISE by the detectors.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10
    } edge_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_LATCH = 2'b10
    } state_t;

endpackage

// File: rtl/multi_input_counter_edge_sync_detect.sv
// One channel: input synchroniser, previous-sample register and registered,
// mode-qualified edge strobe.
module edge_sync_detect
    import multi_input_counter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_signal,
    input  logic [1:0] i_edge_mode,
    output logic       o_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    logic                   rise, fall;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_signal};
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall   = ~sync_q[SYNC_STAGES-1] & prev_q;
        case (i_edge_mode)
            EDGE_FALL: edge_d = fall;
            EDGE_BOTH: edge_d = rise | fall;
            default:   edge_d = rise;
        endcase
    end

    // The strobe is registered so a transition stable before edge t reaches
    // the live count on edge t+SYNC_STAGES+1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign o_edge = edge_q;

endmodule

// File: rtl/multi_input_counter.sv
// Multi-channel gated edge counter with saturation, snapshot-on-close and valid strobe.
// Optional MULTI_INPUT_COUNTER_WINDOW_LEN_EN adds o_window_len (COUNT cycles of last window).
module multi_input_counter
    import multi_input_counter_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_CH-1:0]       i_signal,
    input  logic                  i_gate,
    input  logic [1:0]            i_edge_mode,
    input  logic                  i_clear,
    output logic [N_CH*CNT_W-1:0] o_count,
    output logic [N_CH*CNT_W-1:0] o_latched,
    output logic [N_CH-1:0]       o_overflow,
    output logic                  o_valid
`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
    ,
    output logic [CNT_W-1:0]      o_window_len
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t          state_q, state_d;
    logic            gate_q, gate_d;
    logic            win_open, counting, closing;
    logic [N_CH-1:0] edge_w;

    always_comb begin
        gate_d   = i_gate;
        win_open = i_gate && !gate_q && (state_q != ST_COUNT);
        counting = (state_q == ST_COUNT) && i_gate;
        closing  = (state_q == ST_COUNT) && !i_gate;
        state_d  = state_q;
        case (state_q)
            ST_IDLE:  if (win_open) state_d = ST_COUNT;
            ST_COUNT: if (!i_gate) state_d = ST_LATCH;
            ST_LATCH: state_d = win_open ? ST_COUNT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // gate_q resets high so a gate still held high after reset cannot open a window.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
        end
    end

    assign o_valid = (state_q == ST_LATCH);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] lat_q, lat_d;
            logic             ovf_q, ovf_d;

            edge_sync_detect #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_detect (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_signal   (i_signal[gi]),
                .i_edge_mode(i_edge_mode),
                .o_edge     (edge_w[gi])
            );

            // The snapshot is taken on the closing edge (counts are frozen then),
            // so o_latched is already valid during the LATCH/o_valid cycle.
            always_comb begin
                cnt_d = cnt_q;
                ovf_d = ovf_q;
                lat_d = closing ? cnt_q : lat_q;
                if (i_clear) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (win_open) begin
                    cnt_d = edge_w[gi] ? CNT_W'(1) : '0;
                    ovf_d = 1'b0;
                end else if (counting && edge_w[gi]) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    cnt_q <= '0;
                    lat_q <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lat_q <= lat_d;
                    ovf_q <= ovf_d;
                end
            end

            assign o_count[gi*CNT_W +: CNT_W]   = cnt_q;
            assign o_latched[gi*CNT_W +: CNT_W] = lat_q;
            assign o_overflow[gi]               = ovf_q;
        end
    endgenerate

`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
    logic [CNT_W-1:0] wlen_cnt_q, wlen_cnt_d;
    logic [CNT_W-1:0] wlen_q, wlen_d;
    logic [CNT_W-1:0] wlen_inc;

    // The closing COUNT cycle is included, hence the snapshot of the incremented value.
    always_comb begin
        wlen_inc   = (wlen_cnt_q == CNT_MAX) ? wlen_cnt_q : wlen_cnt_q + CNT_W'(1);
        wlen_cnt_d = wlen_cnt_q;
        wlen_d     = wlen_q;
        if (win_open) begin
            wlen_cnt_d = '0;
        end else if (state_q == ST_COUNT) begin
            wlen_cnt_d = wlen_inc;
        end
        if (closing) wlen_d = wlen_inc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wlen_cnt_q <= '0;
            wlen_q     <= '0;
        end else begin
            wlen_cnt_q <= wlen_cnt_d;
            wlen_q     <= wlen_d;
        end
    end

    assign o_window_len = wlen_q;
`endif

endmodule

// File: tb/tb_multi_input_counter.sv
// Directed self-checking bench for multi_input_counter (N_CH=4, CNT_W=8, SYNC_STAGES=2).
module tb_multi_input_counter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int SS    = 2;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic [N_CH-1:0]       i_signal;
    logic                  i_gate;
    logic [1:0]            i_edge_mode;
    logic                  i_clear;
    logic [N_CH*CNT_W-1:0] o_count;
    logic [N_CH*CNT_W-1:0] o_latched;
    logic [N_CH-1:0]       o_overflow;
    logic                  o_valid;
`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
    logic [CNT_W-1:0]      o_window_len;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_input_counter #(
        .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SS)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_signal   (i_signal),
        .i_gate     (i_gate),
        .i_edge_mode(i_edge_mode),
        .i_clear    (i_clear),
        .o_count    (o_count),
        .o_latched  (o_latched),
        .o_overflow (o_overflow),
        .o_valid    (o_valid)
`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
        ,
        .o_window_len(o_window_len)
`endif
    );

    function automatic logic [CNT_W-1:0] cnt(input int k);
        return o_count[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] lat(input int k);
        return o_latched[k*CNT_W +: CNT_W];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulses(input logic [N_CH-1:0] mask, input int n);
        repeat (n) begin
            i_signal = i_signal | mask;
            tick(1);
            i_signal = i_signal & ~mask;
            tick(1);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_signal = '0; i_gate = 1'b0; i_edge_mode = 2'b00; i_clear = 1'b0;
        tick(3);
        i_reset = 1'b0;
        tick(1);
        n_checks += 4;
        if (o_count !== '0)    begin n_fail++; $display("FAIL reset_count: got %h want 0", o_count); end
        if (o_latched !== '0)  begin n_fail++; $display("FAIL reset_latched: got %h want 0", o_latched); end
        if (o_overflow !== '0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
        if (o_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        $display("test_reset done");
    endtask

    task automatic test_rising();
        int want [N_CH] = '{10, 20, 30, 40};
        logic [N_CH-1:0] m;
        i_edge_mode = 2'b00;
        i_gate = 1'b1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N_CH; k++) m[k] = (i < want[k]);
            pulses(m, 1);
        end
        tick(119);
        i_gate = 1'b0;
        tick(1);
        n_checks += 2;
        if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL rise_valid: got %b want 1", o_valid); end
        if (o_overflow !== '0)   begin n_fail++; $display("FAIL rise_overflow: got %b want 0", o_overflow); end
        for (int k = 0; k < N_CH; k++) begin
            n_checks++;
            if (lat(k) !== CNT_W'(want[k])) begin
                n_fail++; $display("FAIL rise_latched ch%0d: got %0d want %0d", k, lat(k), want[k]);
            end
        end
        tick(1);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rise_valid_one_cycle: got %b want 0", o_valid); end
        $display("test_rising latched %0d/%0d/%0d/%0d", lat(0), lat(1), lat(2), lat(3));
    endtask

    task automatic test_both_edge();
        i_edge_mode = 2'b10;
        i_gate = 1'b1; tick(1);
        pulses(4'b0010, 5); tick(5);
        i_gate = 1'b0; tick(1);
        n_checks += 2;
        if (o_valid !== 1'b1)      begin n_fail++; $display("FAIL both_valid: got %b want 1", o_valid); end
        if (lat(1) !== CNT_W'(10)) begin n_fail++; $display("FAIL both_count: got %0d want 10", lat(1)); end
        tick(1);
        i_edge_mode = 2'b01;
        i_gate = 1'b1; tick(1);
        pulses(4'b0010, 5); tick(5);
        i_gate = 1'b0; tick(1);
        n_checks++;
        if (lat(1) !== CNT_W'(5)) begin n_fail++; $display("FAIL fall_count: got %0d want 5", lat(1)); end
        tick(1);
        i_edge_mode = 2'b00;
        $display("test_both_edge done");
    endtask

    task automatic test_saturation();
        i_gate = 1'b1; tick(1);
        pulses(4'b0001, 300); tick(5);
        n_checks += 3;
        if (cnt(0) !== 8'd255)        begin n_fail++; $display("FAIL sat_count: got %0d want 255", cnt(0)); end
        if (o_overflow !== 4'b0001)   begin n_fail++; $display("FAIL sat_overflow: got %b want 0001", o_overflow); end
        if (cnt(1) !== 8'd0)          begin n_fail++; $display("FAIL sat_ch1_isolated: got %0d want 0", cnt(1)); end
        i_gate = 1'b0; tick(1);
        n_checks++;
        if (lat(0) !== 8'd255) begin n_fail++; $display("FAIL sat_latched: got %0d want 255", lat(0)); end
        tick(1);
        i_gate = 1'b1; tick(2);
        n_checks += 2;
        if (cnt(0) !== 8'd0)     begin n_fail++; $display("FAIL sat_reopen_count: got %0d want 0", cnt(0)); end
        if (o_overflow !== '0)   begin n_fail++; $display("FAIL sat_reopen_overflow: got %b want 0", o_overflow); end
        i_gate = 1'b0; tick(2);
        $display("test_saturation done");
    endtask

    task automatic test_gate_boundaries();
        // Edge strobe arrives in the very cycle the gate is first seen low.
        i_gate = 1'b1; tick(1);
        pulses(4'b0001, 2); tick(5);
        i_signal[0] = 1'b1; tick(3);
        i_gate = 1'b0; tick(1);
        n_checks += 2;
        if (o_valid !== 1'b1)     begin n_fail++; $display("FAIL fall_cycle_valid: got %b want 1", o_valid); end
        if (lat(0) !== CNT_W'(2)) begin n_fail++; $display("FAIL fall_cycle_edge: got %0d want 2", lat(0)); end
        i_signal[0] = 1'b0; tick(2);
        // Edge strobe arrives in the very cycle the gate opens.
        i_signal[0] = 1'b1; tick(3);
        i_gate = 1'b1; tick(1);
        i_signal[0] = 1'b0; tick(5);
        n_checks++;
        if (cnt(0) !== CNT_W'(1)) begin n_fail++; $display("FAIL rise_cycle_edge: got %0d want 1", cnt(0)); end
        // Gate low for exactly one cycle.
        pulses(4'b0100, 3); tick(5);
        i_gate = 1'b0; tick(1);
        n_checks += 3;
        if (o_valid !== 1'b1)     begin n_fail++; $display("FAIL short_low_valid: got %b want 1", o_valid); end
        if (lat(2) !== CNT_W'(3)) begin n_fail++; $display("FAIL short_low_latched2: got %0d want 3", lat(2)); end
        if (lat(0) !== CNT_W'(1)) begin n_fail++; $display("FAIL short_low_latched0: got %0d want 1", lat(0)); end
        i_gate = 1'b1; tick(1);
        n_checks += 3;
        if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL short_low_valid_drop: got %b want 0", o_valid); end
        if (cnt(2) !== CNT_W'(0)) begin n_fail++; $display("FAIL short_low_clear2: got %0d want 0", cnt(2)); end
        if (cnt(0) !== CNT_W'(0)) begin n_fail++; $display("FAIL short_low_clear0: got %0d want 0", cnt(0)); end
        pulses(4'b0100, 1); tick(5);
        n_checks++;
        if (cnt(2) !== CNT_W'(1)) begin n_fail++; $display("FAIL short_low_recount: got %0d want 1", cnt(2)); end
        i_gate = 1'b0; tick(2);
        $display("test_gate_boundaries done");
    endtask

    task automatic test_clear_reset();
        int seen;
        i_gate = 1'b1; tick(1);
        pulses(4'b1000, 7); tick(5);
        n_checks++;
        if (cnt(3) !== CNT_W'(7)) begin n_fail++; $display("FAIL clear_pre: got %0d want 7", cnt(3)); end
        i_clear = 1'b1; tick(1); i_clear = 1'b0;
        n_checks++;
        if (cnt(3) !== CNT_W'(0)) begin n_fail++; $display("FAIL clear_zero: got %0d want 0", cnt(3)); end
        pulses(4'b1000, 3); tick(5);
        i_gate = 1'b0; tick(1);
        n_checks += 2;
        if (o_valid !== 1'b1)     begin n_fail++; $display("FAIL clear_valid: got %b want 1", o_valid); end
        if (lat(3) !== CNT_W'(3)) begin n_fail++; $display("FAIL clear_latched: got %0d want 3", lat(3)); end
        tick(1);
        // Reset in the middle of an open window.
        i_gate = 1'b1; tick(1);
        pulses(4'b1000, 7); tick(5);
        i_reset = 1'b1; tick(1); i_reset = 1'b0;
        n_checks += 4;
        if (o_count !== '0)    begin n_fail++; $display("FAIL midreset_count: got %h want 0", o_count); end
        if (o_latched !== '0)  begin n_fail++; $display("FAIL midreset_latched: got %h want 0", o_latched); end
        if (o_overflow !== '0) begin n_fail++; $display("FAIL midreset_overflow: got %b want 0", o_overflow); end
        if (o_valid !== 1'b0)  begin n_fail++; $display("FAIL midreset_valid: got %b want 0", o_valid); end
        seen = 0;
        pulses(4'b1000, 2);
        for (int i = 0; i < 5; i++) begin tick(1); if (o_valid) seen++; end
        n_checks++;
        if (cnt(3) !== CNT_W'(0)) begin n_fail++; $display("FAIL midreset_no_window: got %0d want 0", cnt(3)); end
        i_gate = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(1); if (o_valid) seen++; end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses want 0", seen); end
        i_gate = 1'b1; tick(1);
        pulses(4'b1000, 1); tick(5);
        n_checks++;
        if (cnt(3) !== CNT_W'(1)) begin n_fail++; $display("FAIL midreset_reopen: got %0d want 1", cnt(3)); end
        i_gate = 1'b0; tick(2);
        $display("test_clear_reset done");
    endtask

`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
    task automatic test_window_len();
        i_gate = 1'b1; tick(123);
        i_gate = 1'b0; tick(1);
        n_checks += 2;
        if (o_valid !== 1'b1)          begin n_fail++; $display("FAIL wlen_valid: got %b want 1", o_valid); end
        if (o_window_len !== 8'd123)   begin n_fail++; $display("FAIL wlen_value: got %0d want 123", o_window_len); end
        tick(2);
        $display("test_window_len len=%0d", o_window_len);
    endtask
`endif

    initial begin
        test_reset();
        test_rising();
        test_both_edge();
        test_saturation();
        test_gate_boundaries();
        test_clear_reset();
`ifdef MULTI_INPUT_COUNTER_WINDOW_LEN_EN
        test_window_len();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
